// File: rtl/spmp_csr_regfile.sv
// SPMP CSR register file: spmpcfg/spmpaddr/spmpswitch with WARL legalization and flush sequencing.
// Define SPMP_FLUSH_HANDSHAKE_EN to wait for flush_ack_i after writes; otherwise flush_req_o is a pulse.
module spmp_csr_regfile #(
  parameter int unsigned NrSPMPEntries = 8,
  parameter int unsigned PLEN          = 56,
  parameter logic [11:0] CfgBase       = 12'h1A0,
  parameter logic [11:0] AddrBase      = 12'h1B0,
  parameter logic [11:0] SwitchAddr    = 12'h170
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  logic                                       req_we_i,
  input  logic [11:0]                                req_addr_i,
  input  logic [63:0]                                req_wdata_i,
  output logic                                       rsp_valid_o,
  output logic [63:0]                                rsp_rdata_o,
  output logic                                       rsp_err_o,
  output logic [((NrSPMPEntries == 0) ? 1 : NrSPMPEntries)-1:0][7:0]     spmpcfg_o,
  output logic [((NrSPMPEntries == 0) ? 1 : NrSPMPEntries)-1:0][PLEN-3:0] spmpaddr_o,
  output logic [63:0]                                spmpswitch_o,
  output logic                                       flush_req_o,
  input  logic                                       flush_ack_i
);

  localparam int unsigned N  = NrSPMPEntries;
  localparam int unsigned NW = (N == 0) ? 1 : N;
  localparam logic [63:0] SwMask = (N >= 64) ? '1 : ((64'd1 << N) - 64'd1);

`ifdef SPMP_FLUSH_HANDSHAKE_EN
  typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_t;
  logic wr_pending;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
  logic unused_flush_ack;
  assign unused_flush_ack = flush_ack_i;
`endif

  state_t                   state;
  logic                     ready_q, rsp_valid_q, err_q, flush_q;
  logic [63:0]              rdata_q, rd, sw_q;
  logic [NW-1:0][7:0]       cfg_q;
  logic [NW-1:0][PLEN-3:0]  addr_q;
  logic [3:0]               cfg_idx;
  logic [5:0]               addr_idx;
  logic                     in_cfg, sel_cfg, sel_addr, sel_sw, dec_err, accept, do_write;
  logic [7:0][7:0]          wbyte;
  logic [7:0]               wok;

  assign cfg_idx  = 4'(req_addr_i - CfgBase);
  assign addr_idx = 6'(req_addr_i - AddrBase);
  assign in_cfg   = (req_addr_i >= CfgBase) && (req_addr_i <= CfgBase + 12'd15);
  assign sel_cfg  = in_cfg && !cfg_idx[0];
  assign sel_addr = (req_addr_i >= AddrBase) && (req_addr_i <= AddrBase + 12'd63);
  assign sel_sw   = (req_addr_i == SwitchAddr);
  assign dec_err  = !(sel_cfg || sel_addr || sel_sw);
  assign accept   = req_valid_i && ready_q;
  assign do_write = accept && req_we_i && !dec_err;

  // Per-byte WARL: reserved bits cleared; s_mode with XWR=000 leaves the entry untouched.
  always_comb begin
    wbyte = '0;
    wok   = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      wbyte[j] = {req_wdata_i[8*j+7], 2'b00, req_wdata_i[8*j +: 5]};
      wok[j]   = !(req_wdata_i[8*j+7] && (req_wdata_i[8*j +: 3] == 3'b000));
    end
  end

  always_comb begin
    rd = '0;
    if (sel_cfg) begin
      for (int unsigned e = 0; e < N; e++)
        if ((e >> 3) == 32'(cfg_idx[3:1])) rd[{e[2:0], 3'b000} +: 8] = cfg_q[e];
    end else if (sel_addr) begin
      for (int unsigned e = 0; e < N; e++)
        if (e == 32'(addr_idx)) rd[PLEN-3:0] = addr_q[e];
    end else if (sel_sw) begin
      rd = sw_q;
    end
  end

  // ready is registered from the next state, so it rises one cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      rdata_q     <= '0;
      sw_q        <= '0;
      cfg_q       <= '0;
      addr_q      <= '0;
`ifdef SPMP_FLUSH_HANDSHAKE_EN
      wr_pending  <= 1'b0;
`endif
    end else begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      rdata_q     <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= dec_err;
            rdata_q     <= (req_we_i || dec_err) ? '0 : rd;
`ifdef SPMP_FLUSH_HANDSHAKE_EN
            wr_pending  <= do_write;
`else
            flush_q     <= do_write;
`endif
          end else begin
            ready_q <= 1'b1;
          end
        end
        RESP: begin
`ifdef SPMP_FLUSH_HANDSHAKE_EN
          if (wr_pending) begin
            state   <= FLUSH;
            flush_q <= 1'b1;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_ack_i) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            flush_q <= 1'b1;
          end
`else
          state   <= IDLE;
          ready_q <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase

      if (do_write) begin
        if (sel_cfg) begin
          for (int unsigned e = 0; e < N; e++)
            if (((e >> 3) == 32'(cfg_idx[3:1])) && wok[e[2:0]]) cfg_q[e] <= wbyte[e[2:0]];
        end
        if (sel_addr) begin
          for (int unsigned e = 0; e < N; e++)
            if (e == 32'(addr_idx)) addr_q[e] <= req_wdata_i[PLEN-3:0];
        end
        if (sel_sw) sw_q <= req_wdata_i & SwMask;
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign flush_req_o  = flush_q;
  assign spmpcfg_o    = cfg_q;
  assign spmpaddr_o   = addr_q;
  assign spmpswitch_o = sw_q;

endmodule
